// File: rtl/fft_reorder_if.sv
// rtl/fft_reorder_if.sv - sample stream bus for the FFT output reorder buffer
interface fft_reorder_if #(
  parameter int N_LOG2 = 2,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              out_valid;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [N_LOG2-1:0] out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_re, in_im,
    input  out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im,
    output out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong buffer turning bit-reversed FFT output into natural order
module fft_reorder #(
  parameter int N_LOG2 = 2,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  fft_reorder_if.slave  io_bus
);
  localparam int                N    = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2*DATA_W-1:0] r_mem [0:2*N-1];
  logic [N_LOG2-1:0]   r_wcnt;
  logic [N_LOG2-1:0]   r_rcnt;
  logic                r_wbank;
  logic                r_rbank;
  logic                r_out_valid;
  logic                r_out_last;
  logic [DATA_W-1:0]   r_out_re;
  logic [DATA_W-1:0]   r_out_im;
  logic [N_LOG2-1:0]   r_out_idx;

  logic                w_wr_en;
  logic                w_frame_done;
  logic                w_rd_en;
  logic [N_LOG2:0]     w_waddr;
  logic [N_LOG2:0]     w_raddr;
  logic [2*DATA_W-1:0] w_rdata;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  // Samples arriving while rst is high are dropped so the next frame starts clean.
  assign w_wr_en      = io_bus.in_valid && !rst;
  assign w_frame_done = w_wr_en && (r_wcnt == LAST);
  assign w_rd_en      = (r_state == S_READ);
  assign w_waddr      = {r_wbank, bitrev(r_wcnt)};
  assign w_raddr      = {r_rbank, r_rcnt};
  assign w_rdata      = r_mem[w_raddr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_done) w_state_nxt = S_READ;
      S_READ:  if ((r_rcnt == LAST) && !w_frame_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_waddr] <= {io_bus.in_re, io_bus.in_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_frame_done) r_wbank <= ~r_wbank;
      end
      // A completed frame always launches a drain of the bank just filled.
      if (w_frame_done) begin
        r_rbank <= r_wbank;
        r_rcnt  <= '0;
      end else if (w_rd_en) begin
        r_rcnt <= r_rcnt + 1'b1;
      end
      if (w_rd_en) begin
        r_out_valid <= 1'b1;
        r_out_re    <= w_rdata[2*DATA_W-1:DATA_W];
        r_out_im    <= w_rdata[DATA_W-1:0];
        r_out_idx   <= r_rcnt;
        r_out_last  <= (r_rcnt == LAST);
      end else begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_re    = r_out_re;
  assign io_bus.out_im    = r_out_im;
  assign io_bus.out_idx   = r_out_idx;
  assign io_bus.out_last  = r_out_last;
endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - scoreboard bench for the FFT output reorder buffer
module tb_fft_reorder;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_reorder_if #(.N_LOG2(2), .DATA_W(16)) bus4 ();
  fft_reorder_if #(.N_LOG2(3), .DATA_W(16)) bus8 ();

  fft_reorder #(.N_LOG2(2), .DATA_W(16)) dut4 (.clk(clk), .rst(rst), .io_bus(bus4));
  fft_reorder #(.N_LOG2(3), .DATA_W(16)) dut8 (.clk(clk), .rst(rst), .io_bus(bus8));

  typedef struct {
    int          cyc;
    logic [7:0]  idx;
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   perm4 [4] = '{0, 2, 1, 3};
  int   perm8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic [15:0] sp_re [4] = '{16'h0100, 16'h0300, 16'h0200, 16'h0400};
  logic [15:0] sp_im [4] = '{16'h0000, 16'hFF00, 16'h0080, 16'hFF4B};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // c_last is the cycle count when the final sample of the frame was driven.
  task automatic push_frame4(input int c_last, input logic [15:0] re [4], input logic [15:0] im [4]);
    for (int k = 0; k < 4; k++)
      q.push_back('{cyc: c_last + 2 + k, idx: 8'(k), re: re[perm4[k]], im: im[perm4[k]], last: (k == 3)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_re = '0; bus4.in_im = '0;
    bus8.in_valid = 1'b0; bus8.in_re = '0; bus8.in_im = '0;
    repeat (3) tick();
    n_checks++;
    if ({bus4.out_valid, bus4.out_last, bus4.out_re, bus4.out_im, bus4.out_idx} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_dut4: got v=%b l=%b re=%h im=%h idx=%0d, want all 0",
               bus4.out_valid, bus4.out_last, bus4.out_re, bus4.out_im, bus4.out_idx);
    end
    n_checks++;
    if ({bus8.out_valid, bus8.out_last, bus8.out_re, bus8.out_im, bus8.out_idx} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_dut8: got v=%b l=%b re=%h im=%h idx=%0d, want all 0",
               bus8.out_valid, bus8.out_last, bus8.out_re, bus8.out_im, bus8.out_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    exp_t e;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bus4.in_valid = 1'b1; bus4.in_re = sp_re[i]; bus4.in_im = sp_im[i];
          if (i == 3) push_frame4(cyc, sp_re, sp_im);
          tick();
        end
        bus4.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          tick();
          if (bus4.out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL single_extra: got idx=%0d re=%h at cyc %0d, want no output", bus4.out_idx, bus4.out_re, cyc);
            end else begin
              e = q.pop_front();
              if (cyc !== e.cyc || 8'(bus4.out_idx) !== e.idx || bus4.out_re !== e.re || bus4.out_im !== e.im || bus4.out_last !== e.last) begin
                n_fail++;
                $display("FAIL single_sample: got cyc=%0d idx=%0d re=%h im=%h last=%b, want cyc=%0d idx=%0d re=%h im=%h last=%b",
                         cyc, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, e.cyc, e.idx, e.re, e.im, e.last);
              end
            end
          end
        end
      end
    join
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL single_missing: got %0d outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] fr [3][4];
    logic [15:0] fi [3][4];
    int          run = 0;
    int          max_run = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) begin
        fr[f][i] = 16'($urandom);
        fi[f][i] = 16'($urandom);
      end
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1; bus4.in_re = fr[f][i]; bus4.in_im = fi[f][i];
            if (i == 3) push_frame4(cyc, fr[f], fi[f]);
            tick();
          end
        bus4.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 18; c++) begin
          tick();
          if (bus4.out_valid === 1'b1) begin
            run++;
            if (run > max_run) max_run = run;
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL b2b_extra: got idx=%0d re=%h at cyc %0d, want no output", bus4.out_idx, bus4.out_re, cyc);
            end else begin
              e = q.pop_front();
              if (cyc !== e.cyc || 8'(bus4.out_idx) !== e.idx || bus4.out_re !== e.re || bus4.out_im !== e.im || bus4.out_last !== e.last) begin
                n_fail++;
                $display("FAIL b2b_sample: got cyc=%0d idx=%0d re=%h im=%h last=%b, want cyc=%0d idx=%0d re=%h im=%h last=%b",
                         cyc, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, e.cyc, e.idx, e.re, e.im, e.last);
              end
            end
          end else begin
            run = 0;
          end
        end
      end
    join
    n_checks++;
    if (max_run != 12) begin
      n_fail++;
      $display("FAIL b2b_continuous: got %0d consecutive valid cycles, want 12", max_run);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing: got %0d outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   n = 0;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          bus4.in_valid = pat[i];
          bus4.in_re = pat[i] ? sp_re[n] : 16'hDEAD;
          bus4.in_im = pat[i] ? sp_im[n] : 16'hBEEF;
          if (pat[i]) begin
            if (n == 3) push_frame4(cyc, sp_re, sp_im);
            n++;
          end
          tick();
        end
        bus4.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          tick();
          if (bus4.out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL bubble_extra: got idx=%0d re=%h at cyc %0d, want no output", bus4.out_idx, bus4.out_re, cyc);
            end else begin
              e = q.pop_front();
              if (cyc !== e.cyc || 8'(bus4.out_idx) !== e.idx || bus4.out_re !== e.re || bus4.out_im !== e.im || bus4.out_last !== e.last) begin
                n_fail++;
                $display("FAIL bubble_sample: got cyc=%0d idx=%0d re=%h im=%h last=%b, want cyc=%0d idx=%0d re=%h im=%h last=%b",
                         cyc, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, e.cyc, e.idx, e.re, e.im, e.last);
              end
            end
          end
        end
      end
    join
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bubble_missing: got %0d outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t        e;
    int          c_rst = 32'h7fffffff;
    logic        seen_valid = 1'b0;
    logic [15:0] nr [4] = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
    logic [15:0] ni [4] = '{16'h8001, 16'h8003, 16'h8002, 16'h8004};
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          bus4.in_valid = 1'b1; bus4.in_re = 16'hA5A0 + 16'(i); bus4.in_im = 16'h5A50 + 16'(i);
          tick();
        end
        rst = 1'b1; bus4.in_valid = 1'b1; bus4.in_re = 16'h7777; bus4.in_im = 16'h6666;
        c_rst = cyc + 1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          bus4.in_valid = 1'b1; bus4.in_re = nr[i]; bus4.in_im = ni[i];
          if (i == 3) push_frame4(cyc, nr, ni);
          tick();
        end
        bus4.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          tick();
          if (bus4.out_valid === 1'b1) begin
            seen_valid = 1'b1;
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL rstf_extra: got idx=%0d re=%h at cyc %0d, want no output", bus4.out_idx, bus4.out_re, cyc);
            end else begin
              e = q.pop_front();
              if (cyc !== e.cyc || 8'(bus4.out_idx) !== e.idx || bus4.out_re !== e.re || bus4.out_im !== e.im || bus4.out_last !== e.last) begin
                n_fail++;
                $display("FAIL rstf_sample: got cyc=%0d idx=%0d re=%h im=%h last=%b, want cyc=%0d idx=%0d re=%h im=%h last=%b",
                         cyc, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, e.cyc, e.idx, e.re, e.im, e.last);
              end
            end
          end else if (cyc >= c_rst && !seen_valid) begin
            n_checks++;
            if ({bus4.out_last, bus4.out_re, bus4.out_im, bus4.out_idx} !== 35'd0) begin
              n_fail++;
              $display("FAIL rstf_zero: got l=%b re=%h im=%h idx=%0d at cyc %0d, want all 0",
                       bus4.out_last, bus4.out_re, bus4.out_im, bus4.out_idx, cyc);
            end
          end
        end
      end
    join
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rstf_missing: got %0d outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset_mid_drain();
    exp_t        e;
    int          c_rst = 32'h7fffffff;
    logic [15:0] ar [4] = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03};
    logic [15:0] ai [4] = '{16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03};
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bus4.in_valid = 1'b1; bus4.in_re = ar[i]; bus4.in_im = ai[i];
          // Only idx 0 of frame A survives: the reset lands on the edge that would issue idx 1.
          if (i == 3) q.push_back('{cyc: cyc + 2, idx: 8'd0, re: ar[0], im: ai[0], last: 1'b0});
          tick();
        end
        bus4.in_valid = 1'b1; bus4.in_re = 16'h0C00; bus4.in_im = 16'h0D00;
        tick();
        rst = 1'b1; bus4.in_valid = 1'b1; bus4.in_re = 16'h0C01; bus4.in_im = 16'h0D01;
        c_rst = cyc + 1;
        tick();
        rst = 1'b0; bus4.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          tick();
          if (cyc == c_rst) begin
            n_checks++;
            if (bus4.out_valid !== 1'b0) begin
              n_fail++;
              $display("FAIL drain_rst_valid: got out_valid=%b after reset edge, want 0", bus4.out_valid);
            end
          end
          if (bus4.out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL drain_extra: got idx=%0d re=%h at cyc %0d, want no output", bus4.out_idx, bus4.out_re, cyc);
            end else begin
              e = q.pop_front();
              if (cyc !== e.cyc || 8'(bus4.out_idx) !== e.idx || bus4.out_re !== e.re || bus4.out_im !== e.im || bus4.out_last !== e.last) begin
                n_fail++;
                $display("FAIL drain_sample: got cyc=%0d idx=%0d re=%h im=%h last=%b, want cyc=%0d idx=%0d re=%h im=%h last=%b",
                         cyc, bus4.out_idx, bus4.out_re, bus4.out_im, bus4.out_last, e.cyc, e.idx, e.re, e.im, e.last);
              end
            end
          end
        end
      end
    join
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_missing: got %0d outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_nlog2_3();
    exp_t e;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          bus8.in_valid = 1'b1;
          bus8.in_re = 16'(perm8[i] * 256);
          bus8.in_im = 16'hF000 + 16'(i);
          if (i == 7)
            for (int k = 0; k < 8; k++)
              q.push_back('{cyc: cyc + 2 + k, idx: 8'(k), re: 16'(k * 256),
                            im: 16'hF000 + 16'(perm8[k]), last: (k == 7)});
          tick();
        end
        bus8.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          tick();
          if (bus8.out_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL n8_extra: got idx=%0d re=%h at cyc %0d, want no output", bus8.out_idx, bus8.out_re, cyc);
            end else begin
              e = q.pop_front();
              if (cyc !== e.cyc || 8'(bus8.out_idx) !== e.idx || bus8.out_re !== e.re || bus8.out_im !== e.im || bus8.out_last !== e.last) begin
                n_fail++;
                $display("FAIL n8_sample: got cyc=%0d idx=%0d re=%h im=%h last=%b, want cyc=%0d idx=%0d re=%h im=%h last=%b",
                         cyc, bus8.out_idx, bus8.out_re, bus8.out_im, bus8.out_last, e.cyc, e.idx, e.re, e.im, e.last);
              end
            end
          end
        end
      end
    join
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL n8_missing: got %0d outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bubbles();
    test_reset_mid_frame();
    test_reset_mid_drain();
    test_nlog2_3();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
